tlb_cam_tags: RTL and testbench

//  Tag-match CAM of the TLB. It holds a VPN, ASID, global bit, page level and valid bit per entry.

---
 rtl/tlb_pkg.sv | 39 +++
 rtl/tlb_cam_tags_if.sv | 49 ++++
 rtl/tlb_cam_line.sv | 85 ++++++++
 rtl/tlb_cam_tags.sv | 62 ++++++
 tb/tb_tlb_cam_tags.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_pkg
//  Purpose  : Shared geometry, types and the superpage-aware VPN compare
//             used by the TLB tag CAM.
//  Contents : TLB_ENTRIES, VPN_SEG_BITS, LEVELS, ASID_BITS, VPN_BITS,
//             PT_BITS, tlb_pagetype_t, tlb_vpn_t, vpn_seg_match()
//  Revision : 1.0  initial release
// ============================================================================
package tlb_pkg;

    localparam int TLB_ENTRIES  = 8;
    localparam int VPN_SEG_BITS = 9;
    localparam int LEVELS       = 3;
    localparam int ASID_BITS    = 16;
    localparam int VPN_BITS     = LEVELS * VPN_SEG_BITS;
    localparam int PT_BITS      = $clog2(LEVELS);

    // 0 = base page, k = level-k superpage
    typedef logic [PT_BITS-1:0]  tlb_pagetype_t;
    typedef logic [VPN_BITS-1:0] tlb_vpn_t;

    // A superpage of level k only pins VPN segments k..LEVELS-1; the lower
    // segments are offset bits inside the superpage and are not compared.
    function automatic logic vpn_seg_match(input tlb_vpn_t      vpn,
                                           input tlb_vpn_t      tag,
                                           input tlb_pagetype_t level);
        logic ok;
        ok = 1'b1;
        for (int l = 0; l < LEVELS; l++) begin
            if ((l >= int'(level)) &&
                (vpn[l*VPN_SEG_BITS +: VPN_SEG_BITS] != tag[l*VPN_SEG_BITS +: VPN_SEG_BITS]))
                ok = 1'b0;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_cam_tags_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_cam_tags_if
//  Purpose  : Lookup / install / sfence.vma bundle of the TLB tag CAM.
//  Modports : master - requester side (drives lookup, write and flush,
//                      receives Matches/CAMHit)
//             slave  - CAM side
//  Revision : 1.0  initial release
// ============================================================================
interface tlb_cam_tags_if;
    import tlb_pkg::*;

    // lookup
    logic                   TLBAccess;
    tlb_vpn_t               VPN;
    logic [ASID_BITS-1:0]   ASID;
    // install
    logic                   TLBWrite;
    logic [TLB_ENTRIES-1:0] WriteEnables;
    tlb_vpn_t               WriteVPN;
    logic [ASID_BITS-1:0]   WriteASID;
    logic                   WriteG;
    tlb_pagetype_t          WritePageType;
    // sfence.vma
    logic                   TLBFlush;
    logic                   FlushVAValid;
    tlb_vpn_t               FlushVPN;
    logic                   FlushASIDValid;
    logic [ASID_BITS-1:0]   FlushASID;
    // result
    logic [TLB_ENTRIES-1:0] Matches;
    logic                   CAMHit;

    modport master (
        output TLBAccess, VPN, ASID,
        output TLBWrite, WriteEnables, WriteVPN, WriteASID, WriteG, WritePageType,
        output TLBFlush, FlushVAValid, FlushVPN, FlushASIDValid, FlushASID,
        input  Matches, CAMHit
    );

    modport slave (
        input  TLBAccess, VPN, ASID,
        input  TLBWrite, WriteEnables, WriteVPN, WriteASID, WriteG, WritePageType,
        input  TLBFlush, FlushVAValid, FlushVPN, FlushASIDValid, FlushASID,
        output Matches, CAMHit
    );

endinterface
`default_nettype wire

// File: rtl/tlb_cam_line.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_cam_line
//  Purpose  : One TLB tag entry: storage, lookup match and flush-hit logic.
//  Ports    : clk, reset (sync, active-low) ; i_access/i_vpn/i_asid lookup ;
//             i_we + i_write_* install (already one-hot gated by the top) ;
//             i_flush + i_flush_* sfence.vma ; o_match entry hit
//  Config   : TLB_ASID_EN - store ASID/G and use them in match and flush;
//             undefined: every entry is ASID-agnostic.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_cam_line
    import tlb_pkg::*;
(
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 i_access,
    input  wire tlb_vpn_t             i_vpn,
    input  wire logic [ASID_BITS-1:0] i_asid,
    input  wire logic                 i_we,
    input  wire tlb_vpn_t             i_write_vpn,
    input  wire logic [ASID_BITS-1:0] i_write_asid,
    input  wire logic                 i_write_g,
    input  wire tlb_pagetype_t        i_write_pt,
    input  wire logic                 i_flush,
    input  wire logic                 i_flush_va_valid,
    input  wire tlb_vpn_t             i_flush_vpn,
    input  wire logic                 i_flush_asid_valid,
    input  wire logic [ASID_BITS-1:0] i_flush_asid,
    output logic                      o_match
);

    logic          r_valid;
    tlb_vpn_t      r_vpn;
    tlb_pagetype_t r_pt;
    logic          w_asid_hit;
    logic          w_flush_asid_hit;
    logic          w_flush_va_hit;
    logic          w_flush_hit;

`ifdef TLB_ASID_EN
    logic [ASID_BITS-1:0] r_asid;
    logic                 r_g;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_asid <= i_write_asid;
            r_g    <= i_write_g;
        end
    end

    // Global pages are shared by every address space.
    assign w_asid_hit       = r_g | (i_asid == r_asid);
    // An ASID-selective fence never touches global pages.
    assign w_flush_asid_hit = !i_flush_asid_valid | (!r_g & (i_flush_asid == r_asid));
`else
    logic w_unused_asid;
    assign w_unused_asid    = ^{i_asid, i_write_asid, i_write_g, i_flush_asid_valid, i_flush_asid};
    assign w_asid_hit       = 1'b1;
    assign w_flush_asid_hit = 1'b1;
`endif

    assign w_flush_va_hit = !i_flush_va_valid | vpn_seg_match(i_flush_vpn, r_vpn, r_pt);
    assign w_flush_hit    = i_flush & r_valid & w_flush_va_hit & w_flush_asid_hit;
    assign o_match        = i_access & r_valid & w_asid_hit & vpn_seg_match(i_vpn, r_vpn, r_pt);

    // Tag fields are deliberately not reset; Valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_vpn <= i_write_vpn;
            r_pt  <= i_write_pt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            r_valid <= 1'b0;
        else if (w_flush_hit)
            r_valid <= 1'b0;
        else if (i_we)
            r_valid <= 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/tlb_cam_tags.sv
`default_nettype none
// ============================================================================
//  Module   : tlb_cam_tags
//  Purpose  : Tag-match CAM of the TLB. Zero-latency one-hot lookup,
//             install from the replacement block's one-hot WriteEnables,
//             full and selective sfence.vma flush.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous, active-low
//             bus    - tlb_cam_tags_if.slave (lookup/install/flush/Matches)
//  Config   : TLB_ASID_EN - ASID/G compare and ASID-selective flush.
//             Undefined: ASID ignored, FlushASIDValid ignored.
//  Revision : 1.0  initial release
// ============================================================================
module tlb_cam_tags
    import tlb_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset,
    tlb_cam_tags_if.slave bus
);

    logic [TLB_ENTRIES-1:0] w_we;
    logic [TLB_ENTRIES-1:0] w_matches;

    // A fence in the same cycle wins and the install is dropped; the walker
    // re-walks on the next miss. Reset likewise suppresses the install.
    assign w_we = (bus.TLBWrite && reset && !bus.TLBFlush) ? bus.WriteEnables : '0;

    generate
        for (genvar i = 0; i < TLB_ENTRIES; i++) begin : g_line
            tlb_cam_line u_line (
                .clk                (clk),
                .reset              (reset),
                .i_access           (bus.TLBAccess),
                .i_vpn              (bus.VPN),
                .i_asid             (bus.ASID),
                .i_we               (w_we[i]),
                .i_write_vpn        (bus.WriteVPN),
                .i_write_asid       (bus.WriteASID),
                .i_write_g          (bus.WriteG),
                .i_write_pt         (bus.WritePageType),
                .i_flush            (bus.TLBFlush),
                .i_flush_va_valid   (bus.FlushVAValid),
                .i_flush_vpn        (bus.FlushVPN),
                .i_flush_asid_valid (bus.FlushASIDValid),
                .i_flush_asid       (bus.FlushASID),
                .o_match            (w_matches[i])
            );
        end
    endgenerate

    assign bus.Matches = w_matches;
    assign bus.CAMHit  = |w_matches;

    a_we_onehot: assert property (@(posedge clk) disable iff (!reset)
        bus.TLBWrite |-> $onehot0(bus.WriteEnables));

    a_match_onehot: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(w_matches));

endmodule
`default_nettype wire

// File: tb/tb_tlb_cam_tags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlb_cam_tags
//  Purpose  : Self-checking bench for tlb_cam_tags: directed scenarios then
//             randomized traffic against an array-based reference model.
//  Config   : honours TLB_ASID_EN in the same way as the design.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlb_cam_tags;
    import tlb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlb_cam_tags_if bus ();

    tlb_cam_tags dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // reference model: plain per-entry records
    logic                 m_valid [TLB_ENTRIES];
    tlb_vpn_t             m_vpn   [TLB_ENTRIES];
    logic [ASID_BITS-1:0] m_asid  [TLB_ENTRIES];
    logic                 m_g     [TLB_ENTRIES];
    int                   m_pt    [TLB_ENTRIES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Page of size 2^(9*pt) VPNs: same page iff the quotients agree.
    function automatic logic same_page(input tlb_vpn_t a, input tlb_vpn_t b, input int pt);
        return (a >> (pt * VPN_SEG_BITS)) == (b >> (pt * VPN_SEG_BITS));
    endfunction

    function automatic logic [TLB_ENTRIES-1:0] model_matches();
        logic [TLB_ENTRIES-1:0] m;
        logic asid_ok;
        m = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
`ifdef TLB_ASID_EN
            asid_ok = m_g[i] || (bus.ASID == m_asid[i]);
`else
            asid_ok = 1'b1;
`endif
            if (bus.TLBAccess && m_valid[i] && asid_ok && same_page(bus.VPN, m_vpn[i], m_pt[i]))
                m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic model_clock();
        logic asid_ok;
        if (!reset) begin
            for (int i = 0; i < TLB_ENTRIES; i++) m_valid[i] = 1'b0;
        end else if (bus.TLBFlush) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
`ifdef TLB_ASID_EN
                asid_ok = !bus.FlushASIDValid || (!m_g[i] && m_asid[i] == bus.FlushASID);
`else
                asid_ok = 1'b1;
`endif
                if (asid_ok && (!bus.FlushVAValid || same_page(bus.FlushVPN, m_vpn[i], m_pt[i])))
                    m_valid[i] = 1'b0;
            end
        end else if (bus.TLBWrite) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                if (bus.WriteEnables[i]) begin
                    m_valid[i] = 1'b1;
                    m_vpn[i]   = bus.WriteVPN;
                    m_asid[i]  = bus.WriteASID;
                    m_g[i]     = bus.WriteG;
                    m_pt[i]    = int'(bus.WritePageType);
                end
            end
        end
    endtask

    // Inputs are driven at the falling edge; outputs checked 1 unit later,
    // then the model advances with the rising edge.
    task automatic tick(input string tag, input bit do_check);
        logic [TLB_ENTRIES-1:0] exp;
        #1;
        if (do_check) begin
            exp = model_matches();
            check({tag, "/Matches"}, 32'(bus.Matches), 32'(exp));
            check({tag, "/CAMHit"}, 32'(bus.CAMHit), 32'(|exp));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.TLBAccess      = 1'b0;
        bus.TLBWrite       = 1'b0;
        bus.WriteEnables   = '0;
        bus.TLBFlush       = 1'b0;
        bus.FlushVAValid   = 1'b0;
        bus.FlushASIDValid = 1'b0;
    endtask

    task automatic lookup(input tlb_vpn_t v, input logic [ASID_BITS-1:0] a);
        bus.TLBAccess = 1'b1;
        bus.VPN       = v;
        bus.ASID      = a;
    endtask

    task automatic install(input logic [TLB_ENTRIES-1:0] we, input tlb_vpn_t v,
                           input logic [ASID_BITS-1:0] a, input logic g, input int pt);
        bus.TLBWrite      = 1'b1;
        bus.WriteEnables  = we;
        bus.WriteVPN      = v;
        bus.WriteASID     = a;
        bus.WriteG        = g;
        bus.WritePageType = tlb_pagetype_t'(pt);
    endtask

    task automatic fence(input logic vav, input tlb_vpn_t v, input logic asv, input logic [ASID_BITS-1:0] a);
        bus.TLBFlush       = 1'b1;
        bus.FlushVAValid   = vav;
        bus.FlushVPN       = v;
        bus.FlushASIDValid = asv;
        bus.FlushASID      = a;
    endtask

    task automatic expect_now(input string tag, input logic [TLB_ENTRIES-1:0] exp);
        #1;
        check({tag, "/const"}, 32'(bus.Matches), 32'(exp));
    endtask

    initial begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_vpn[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_pt[i] = 0;
        end
        reset = 1'b0;
        quiet();
        bus.VPN = '0; bus.ASID = '0; bus.WriteVPN = '0; bus.WriteASID = '0;
        bus.WriteG = 1'b0; bus.WritePageType = '0; bus.FlushVPN = '0; bus.FlushASID = '0;
        @(negedge clk);

        // 1: reset cycle also carries an install, which must be ignored
        lookup(27'h0001234, 16'd5);
        install(8'h08, 27'h0001234, 16'd5, 1'b0, 0);
        tick("t1_rst", 0);
        reset = 1'b1;
        quiet();
        lookup(27'h0001234, 16'd5);
        expect_now("t1_after_reset", 8'h00);
        tick("t1_after_reset", 1);

        // 2: base page install, lookup in install cycle sees old contents
        install(8'h08, 27'h0001234, 16'd5, 1'b0, 0);
        lookup(27'h0001234, 16'd5);
        expect_now("t2_install_cycle", 8'h00);
        tick("t2_install_cycle", 1);
        quiet();
        lookup(27'h0001234, 16'd5);
        expect_now("t2_hit", 8'h08);
        tick("t2_hit", 1);
        lookup(27'h0001234, 16'd6);
`ifdef TLB_ASID_EN
        expect_now("t2_asid_miss", 8'h00);
`else
        expect_now("t2_asid_ignored", 8'h08);
`endif
        tick("t2_asid", 1);

        // 3: level-1 global superpage
        quiet();
        install(8'h01, 27'h0040000, 16'd7, 1'b1, 1);
        tick("t3_install", 1);
        quiet();
        lookup(27'h00401FF, 16'd9);
        expect_now("t3_super_hit", 8'h01);
        tick("t3_super_hit", 1);
        lookup(27'h0040200, 16'd9);
        expect_now("t3_super_miss", 8'h00);
        tick("t3_super_miss", 1);

        // 4: ASID-only fence, then VA-only fence
        quiet();
        fence(1'b0, '0, 1'b1, 16'd5);
        tick("t4_asid_fence", 0);
        quiet();
        lookup(27'h0001234, 16'd5);
        expect_now("t4_e3_gone", 8'h00);
        tick("t4_e3", 1);
        lookup(27'h00401FF, 16'd5);
`ifdef TLB_ASID_EN
        expect_now("t4_e0_kept", 8'h01);
`else
        expect_now("t4_e0_full_flush", 8'h00);
`endif
        tick("t4_e0", 1);
        quiet();
        fence(1'b1, 27'h0040000, 1'b0, '0);
        tick("t4_va_fence", 0);
        quiet();
        lookup(27'h00401FF, 16'd5);
        expect_now("t4_e0_gone", 8'h00);
        tick("t4_e0_va", 1);

        // 5: fence and install together -> install dropped
        quiet();
        install(8'h02, 27'h0400000, 16'd5, 1'b0, 0);
        tick("t5_prep", 1);
        quiet();
        fence(1'b0, '0, 1'b0, '0);
        install(8'h04, 27'h0800000, 16'd5, 1'b0, 0);
        tick("t5_both", 1);
        quiet();
        lookup(27'h0800000, 16'd5);
        expect_now("t5_write_dropped", 8'h00);
        tick("t5_a", 1);
        lookup(27'h0400000, 16'd5);
        expect_now("t5_flushed", 8'h00);
        tick("t5_b", 1);

        // 6: install-cycle lookup, then ASID behaviour
        quiet();
        install(8'h20, 27'h0C00000, 16'd5, 1'b0, 0);
        lookup(27'h0C00000, 16'd5);
        expect_now("t6_same_cycle", 8'h00);
        tick("t6_same_cycle", 1);
        quiet();
        lookup(27'h0C00000, 16'd5);
        expect_now("t6_next_cycle", 8'h20);
        tick("t6_next_cycle", 1);
        lookup(27'h0C00000, 16'd6);
`ifdef TLB_ASID_EN
        expect_now("t6_asid_mismatch", 8'h00);
`else
        expect_now("t6_asid_mismatch", 8'h20);
`endif
        tick("t6_asid", 1);

        // Random phase. Entry k's top VPN segment is always congruent to k
        // mod 8, so no two valid entries can ever cover the same VPN.
        quiet();
        reset = 1'b0;
        tick("rnd_rst", 0);
        reset = 1'b1;
        for (int n = 0; n < 600; n++) begin
            int k;
            int wk;
            tlb_vpn_t v;
            tlb_vpn_t mask;
            quiet();
            k = int'($urandom_range(0, TLB_ENTRIES - 1));
            bus.TLBAccess = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 2) != 0) begin
                mask = tlb_vpn_t'((64'd1 << (m_pt[k] * VPN_SEG_BITS)) - 64'd1);
                v = (m_vpn[k] & ~mask) | (tlb_vpn_t'($urandom) & mask);
                if ($urandom_range(0, 4) == 0)
                    v = v ^ (tlb_vpn_t'(1) << $urandom_range(0, VPN_BITS - 1));
            end else begin
                v = tlb_vpn_t'($urandom);
            end
            bus.VPN  = v;
            bus.ASID = ($urandom_range(0, 1) == 1) ? m_asid[k] : ASID_BITS'($urandom_range(5, 7));
            if ($urandom_range(0, 99) < 25) begin
                wk = int'($urandom_range(0, TLB_ENTRIES - 1));
                install(($urandom_range(0, 7) == 0) ? '0 : TLB_ENTRIES'(1) << wk,
                        {VPN_SEG_BITS'(($urandom_range(0, 63) << 3) | wk),
                         (VPN_BITS - VPN_SEG_BITS)'($urandom)},
                        ASID_BITS'($urandom_range(5, 7)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, LEVELS - 1)));
            end
            if ($urandom_range(0, 99) < 8) begin
                k = int'($urandom_range(0, TLB_ENTRIES - 1));
                fence(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0) ? (m_vpn[k] ^ tlb_vpn_t'($urandom_range(0, 511)))
                                                  : tlb_vpn_t'($urandom),
                      1'($urandom_range(0, 1)), ASID_BITS'($urandom_range(5, 7)));
            end
            reset = ($urandom_range(0, 99) != 0);
            tick("rnd", 1);
            reset = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
